smoke_input_conditioner: RTL and testbench
==========================================

Name: smoke_input_conditioner

Overview:
Front-end conditioning stage feeding the emergency alarm controller.
- Synchronises the raw smoke-sensor digital output (MQ-type, active-low) and the raw activate push-button (active-low) into the clk domain.
- Qualifies smoke with a sampled persistence filter and debounces the button.
- Delivers clean active-high levels `smoke_detected` and `btn_activate`, on which the alarm controller performs its own rising-edge detection.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each raw input (min 2).
- SAMPLE_PERIOD, 2_500_000, clk cycles between smoke samples (50 ms at 50 MHz); min 1.
- CONFIRM_SAMPLES, 8, consecutive asserted samples required to declare smoke; min 1.
- CLEAR_SAMPLES, 16, consecutive deasserted samples required to clear smoke; min 1.
- DEBOUNCE_CYCLES, 1_000_000, clk cycles the button must be stable before the output follows (20 ms); min 1.
- WARMUP_CYCLES, 1_500_000_000, sensor warm-up inhibit (30 s); used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- smoke_raw_n  in  1  async sensor output, low = gas present.
- btn_raw_n  in  1  async push-button, low = pressed.
- smoke_detected  out  1  qualified smoke level, active-high, registered.
- btn_activate  out  1  debounced button level, active-high, registered.
- smoke_state  out  2  current filter FSM state (debug/LED).
- sensor_ready  out  1  high once warm-up is complete.

Behaviour:
Reset values:
- smoke_detected=0, btn_activate=0, smoke_state=CLEAR(0).
- Prescaler, sample counter and debounce counter are cleared.
- Synchroniser stages load 1 (the idle level of an active-low input).
- sensor_ready: see Optional Feature.
- Reset mid-operation aborts any confirm/release sequence and returns to CLEAR on the next edge.

Synchronisation and polarity:
- smoke_s = ~(last sync stage of smoke_raw_n).
- btn_s = ~(last sync stage of btn_raw_n).
- Latency: SYNC_STAGES cycles.

Prescaler:
- Counts 0..SAMPLE_PERIOD-1.
- `tick` is high for one cycle when the count equals SAMPLE_PERIOD-1, then wraps to 0.
- Free-running in all states.

Smoke FSM (encoding CLEAR=0, CONFIRMING=1, DETECTED=2, RELEASING=3). State changes only on a tick cycle; cnt is the sample counter.
- CLEAR:
  - tick & smoke_s: go to CONFIRMING with cnt=1.
  - If CONFIRM_SAMPLES==1, go directly to DETECTED instead.
- CONFIRMING:
  - tick & smoke_s: cnt++; when cnt+1 == CONFIRM_SAMPLES, go to DETECTED.
  - tick & !smoke_s: go to CLEAR, cnt=0. Samples must be strictly consecutive.
- DETECTED:
  - tick & !smoke_s: go to RELEASING with cnt=1.
  - If CLEAR_SAMPLES==1, go directly to CLEAR instead.
- RELEASING:
  - tick & !smoke_s: cnt++; when cnt+1 == CLEAR_SAMPLES, go to CLEAR.
  - tick & smoke_s: go to DETECTED, cnt=0.

Output rules:
- smoke_detected = (next_state is DETECTED or RELEASING), registered.
- It rises on the clk edge that ends the confirming tick cycle.
- It never glitches low during RELEASING.
- Worst-case assertion latency from a raw edge: SYNC_STAGES + CONFIRM_SAMPLES*SAMPLE_PERIOD cycles.
- cnt width is clog2(max(CONFIRM_SAMPLES, CLEAR_SAMPLES)+1). It is saturating and never wraps.

Button debouncer:
- btn_activate changes only when btn_s has differed from btn_activate for DEBOUNCE_CYCLES consecutive cycles.
- Any cycle with btn_s == btn_activate clears the counter.
- On reaching DEBOUNCE_CYCLES-1, the output toggles on the next edge and the counter clears.
- A pulse shorter than DEBOUNCE_CYCLES produces no output change.
- Press and release are debounced symmetrically.

Simultaneous events:
- Smoke and button paths are independent; both outputs may change on the same edge.
- reset has priority over everything.

Optional Feature:
SMOKE_WARMUP_EN
- Defined:
  - A warm-up counter runs from reset up to WARMUP_CYCLES-1.
  - Until it completes: sensor_ready=0, the FSM is held in CLEAR, and smoke_detected=0. Sensor transients during heater warm-up are ignored.
  - sensor_ready rises on the edge the counter completes, then stays 1 until reset.
  - The button path is unaffected.
- Not defined:
  - No warm-up counter exists.
  - sensor_ready is constant 1 (including during reset).
  - WARMUP_CYCLES is ignored.

Decomposition:
- Package smoke_cond_pkg holds:
  - the 2-bit state typedef and state constants (CLEAR/CONFIRMING/DETECTED/RELEASING);
  - default timing constants for 50 MHz.
- Sub-module input_debouncer (synchroniser + debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES):
  - instantiated once for the button;
  - reusable for the board's other push-buttons.
- The smoke path synchroniser stays inline.

Test Plan:
Bench parameters: SYNC_STAGES=2, SAMPLE_PERIOD=4, CONFIRM_SAMPLES=3, CLEAR_SAMPLES=4, DEBOUNCE_CYCLES=5, WARMUP_CYCLES=20.
1. Reset, then smoke_raw_n held high for 100 cycles -> smoke_detected=0, smoke_state=0, btn_activate=0 throughout.
2. Drive smoke_raw_n low and hold -> smoke_state goes 1 on the first tick after sync; smoke_detected=1 after the 3rd consecutive sampled low (within 2+12 cycles of the raw edge).
3. From DETECTED, release smoke for 3 samples then reassert for 1 sample -> smoke_state 3 then 2. smoke_detected stays 1 continuously. Then release for 4 samples -> smoke_detected=0, state 0.
4. Button bounce: btn_raw_n low 3 cycles, high 2, low 10 -> exactly one rise of btn_activate, 5 cycles after the stable low is synchronised. Release with a 4-cycle glitch -> no change; a stable high for 5 cycles -> btn_activate=0.
5. Assert reset during CONFIRMING (cnt=2) with smoke still low -> state=0 next edge. Confirmation restarts from cnt=1 after reset deasserts.
6. With SMOKE_WARMUP_EN, smoke low from reset -> sensor_ready=0 and smoke_detected=0 for 20 cycles; then sensor_ready=1 and detection follows scenario 2 timing. Without the macro, sensor_ready=1 from cycle 0.

Source files
------------

// File: rtl/smoke_cond_pkg.sv
// Shared types and 50 MHz default timing for the smoke/button input conditioner.
package smoke_cond_pkg;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        CONFIRMING = 2'd1,
        DETECTED   = 2'd2,
        RELEASING  = 2'd3
    } smoke_state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_SAMPLE_PERIOD   = 2_500_000;
    localparam int unsigned DEF_CONFIRM_SAMPLES = 8;
    localparam int unsigned DEF_CLEAR_SAMPLES   = 16;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_WARMUP_CYCLES   = 1_500_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchroniser plus stable-time debouncer for an active-low push-button; level_o is active-high.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n_i,
    output logic level_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sig_s;

    assign sig_s = ~sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sig_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/smoke_input_conditioner.sv
// Smoke persistence filter and button debouncer feeding the alarm controller.
// Optional sensor warm-up inhibit is enabled by defining SMOKE_WARMUP_EN.
module smoke_input_conditioner
    import smoke_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned SAMPLE_PERIOD   = DEF_SAMPLE_PERIOD,
    parameter int unsigned CONFIRM_SAMPLES = DEF_CONFIRM_SAMPLES,
    parameter int unsigned CLEAR_SAMPLES   = DEF_CLEAR_SAMPLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned WARMUP_CYCLES   = DEF_WARMUP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       smoke_raw_n,
    input  logic       btn_raw_n,
    output logic       smoke_detected,
    output logic       btn_activate,
    output logic [1:0] smoke_state,
    output logic       sensor_ready
);

    localparam int unsigned      PW           = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [PW-1:0]    PRESC_LAST   = PW'(SAMPLE_PERIOD - 1);
    localparam int unsigned      NW           = $clog2(max_u(CONFIRM_SAMPLES, CLEAR_SAMPLES) + 1);
    localparam logic [NW-1:0]    CONFIRM_LAST = NW'(CONFIRM_SAMPLES - 1);
    localparam logic [NW-1:0]    CLEAR_LAST   = NW'(CLEAR_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] smoke_sync_q;
    logic                   smoke_s;
    logic [PW-1:0]          presc_q;
    logic                   tick;
    smoke_state_e           state_q;
    logic [NW-1:0]          cnt_q;
    logic [NW-1:0]          cnt_inc;
    logic                   det_q;
    logic                   fsm_en;

    assign smoke_s = ~smoke_sync_q[SYNC_STAGES-1];
    assign tick    = (presc_q == PRESC_LAST);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + NW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            smoke_sync_q <= '1;
            presc_q      <= '0;
        end else begin
            smoke_sync_q <= {smoke_sync_q[SYNC_STAGES-2:0], smoke_raw_n};
            presc_q      <= tick ? '0 : presc_q + PW'(1);
        end
    end

`ifdef SMOKE_WARMUP_EN
    localparam int unsigned   WW        = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);

    logic [WW-1:0] warm_q;
    logic          ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q  <= '0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            warm_q <= warm_q + WW'(1);
            if (warm_q == WARM_LAST) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign fsm_en       = ready_q;
    assign sensor_ready = ready_q;
`else
    assign fsm_en       = 1'b1;
    // WARMUP_CYCLES has no effect in this build; the OR still evaluates to 1.
    assign sensor_ready = 1'b1 | WARMUP_CYCLES[0];
`endif

    // det_q is loaded alongside every state change, so it always equals "next state is DETECTED/RELEASING".
    always_ff @(posedge clk) begin
        if (reset || !fsm_en) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            det_q   <= 1'b0;
        end else if (tick) begin
            case (state_q)
                CLEAR: begin
                    if (smoke_s) begin
                        if (CONFIRM_SAMPLES == 1) begin
                            state_q <= DETECTED;
                            cnt_q   <= '0;
                            det_q   <= 1'b1;
                        end else begin
                            state_q <= CONFIRMING;
                            cnt_q   <= NW'(1);
                        end
                    end
                end
                CONFIRMING: begin
                    if (!smoke_s) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end else if (cnt_q == CONFIRM_LAST) begin
                        state_q <= DETECTED;
                        cnt_q   <= '0;
                        det_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DETECTED: begin
                    if (!smoke_s) begin
                        if (CLEAR_SAMPLES == 1) begin
                            state_q <= CLEAR;
                            cnt_q   <= '0;
                            det_q   <= 1'b0;
                        end else begin
                            state_q <= RELEASING;
                            cnt_q   <= NW'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (smoke_s) begin
                        state_q <= DETECTED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CLEAR_LAST) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        det_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    det_q   <= 1'b0;
                end
            endcase
        end
    end

    assign smoke_detected = det_q;
    assign smoke_state    = state_q;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk    (clk),
        .reset  (reset),
        .raw_n_i(btn_raw_n),
        .level_o(btn_activate)
    );

endmodule

// File: tb/tb_smoke_input_conditioner.sv
// Scoreboard bench: a run-length model predicts every post-edge output, a negedge monitor compares.
module tb_smoke_input_conditioner;

    localparam int SS  = 2;
    localparam int SP  = 4;
    localparam int CFS = 3;
    localparam int CLS = 4;
    localparam int DB  = 5;
    localparam int WC  = 20;
`ifdef SMOKE_WARMUP_EN
    localparam bit WARM_EN = 1'b1;
`else
    localparam bit WARM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, smoke_raw_n, btn_raw_n;
    logic       smoke_detected, btn_activate, sensor_ready;
    logic [1:0] smoke_state;

    always #5 clk = ~clk;

    smoke_input_conditioner #(
        .SYNC_STAGES    (SS),
        .SAMPLE_PERIOD  (SP),
        .CONFIRM_SAMPLES(CFS),
        .CLEAR_SAMPLES  (CLS),
        .DEBOUNCE_CYCLES(DB),
        .WARMUP_CYCLES  (WC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .smoke_raw_n   (smoke_raw_n),
        .btn_raw_n     (btn_raw_n),
        .smoke_detected(smoke_detected),
        .btn_activate  (btn_activate),
        .smoke_state   (smoke_state),
        .sensor_ready  (sensor_ready)
    );

    typedef struct packed {
        logic       det;
        logic [1:0] st;
        logic       btn;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;

    // Model: smoke level plus count of consecutive samples disagreeing with it; button level
    // plus count of consecutive cycles disagreeing with it; sync chains as FIFOs of raw values.
    bit m_smk_pipe[$];
    bit m_btn_pipe[$];
    int m_phase, m_run, m_diff, m_warm;
    bit m_det, m_btn, m_rdy;

    bit count_rises = 1'b0;
    bit btn_prev    = 1'b0;
    int rises       = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic model_edge();
        bit   smk_s, btn_s, tick, en;
        exp_t e;
        if (reset) begin
            m_smk_pipe = {};
            m_btn_pipe = {};
            for (int i = 0; i < SS; i++) begin
                m_smk_pipe.push_back(1'b1);
                m_btn_pipe.push_back(1'b1);
            end
            m_phase = 0;
            m_det   = 1'b0;
            m_run   = 0;
            m_btn   = 1'b0;
            m_diff  = 0;
            m_warm  = 0;
            m_rdy   = !WARM_EN;
        end else begin
            smk_s   = !m_smk_pipe[0];
            btn_s   = !m_btn_pipe[0];
            tick    = (m_phase == SP - 1);
            en      = m_rdy;
            m_phase = (m_phase + 1) % SP;
            if (WARM_EN && !m_rdy) begin
                if (m_warm == WC - 1) m_rdy = 1'b1;
                m_warm++;
            end
            if (!en) begin
                m_det = 1'b0;
                m_run = 0;
            end else if (tick) begin
                if (smk_s != m_det) begin
                    m_run++;
                    if (m_run == (m_det ? CLS : CFS)) begin
                        m_det = !m_det;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            if (btn_s != m_btn) begin
                m_diff++;
                if (m_diff == DB) begin
                    m_btn  = !m_btn;
                    m_diff = 0;
                end
            end else begin
                m_diff = 0;
            end
            void'(m_smk_pipe.pop_front());
            void'(m_btn_pipe.pop_front());
            m_smk_pipe.push_back(smoke_raw_n);
            m_btn_pipe.push_back(btn_raw_n);
        end
        e.det = m_det;
        e.st  = m_det ? ((m_run != 0) ? 2'd3 : 2'd2) : ((m_run != 0) ? 2'd1 : 2'd0);
        e.btn = m_btn;
        e.rdy = m_rdy;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
        if (count_rises && btn_activate && !btn_prev) rises++;
        btn_prev = btn_activate;
    endtask

    task automatic drive(input bit r, input bit s, input bit b, input int n);
        reset       = r;
        smoke_raw_n = s;
        btn_raw_n   = b;
        repeat (n) step();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("smoke_detected", {1'b0, smoke_detected}, {1'b0, e.det});
            check("smoke_state",    smoke_state,            e.st);
            check("btn_activate",   {1'b0, btn_activate},   {1'b0, e.btn});
            check("sensor_ready",   {1'b0, sensor_ready},   {1'b0, e.rdy});
        end
    end

    initial begin
        bit found;
        reset       = 1'b1;
        smoke_raw_n = 1'b1;
        btn_raw_n   = 1'b1;

        // Reset, then idle inputs.
        drive(1, 1, 1, 3);
        drive(0, 1, 1, 100);

        // Smoke asserted and held.
        drive(0, 0, 1, 20);

        // Release 3 samples, reassert 1, then release 4.
        drive(0, 1, 1, 12);
        drive(0, 0, 1, 4);
        drive(0, 1, 1, 20);

        // Button bounce on press, glitch on release.
        drive(0, 1, 1, 10);
        rises       = 0;
        btn_prev    = btn_activate;
        count_rises = 1'b1;
        drive(0, 1, 0, 3);
        drive(0, 1, 1, 2);
        drive(0, 1, 0, 10);
        drive(0, 1, 1, 4);
        drive(0, 1, 0, 3);
        drive(0, 1, 1, 10);
        count_rises = 1'b0;
        check("btn_single_rise", 2'(rises), 2'd1);

        // Reset while CONFIRMING with cnt=2, smoke still low.
        found = 1'b0;
        drive(0, 0, 1, 0);
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = (!m_det && m_run == 2);
        end
        check("confirm_cnt2_reached", {1'b0, found}, 2'd1);
        drive(1, 0, 1, 1);
        drive(0, 0, 1, 50);

        // Smoke low straight out of reset.
        drive(1, 0, 1, 2);
        drive(0, 0, 1, 50);

        // Randomised segments with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            bit r, s, b;
            r = ($urandom_range(0, 39) == 0);
            s = $urandom_range(0, 1);
            b = $urandom_range(0, 1);
            drive(r, s, b, r ? 1 : $urandom_range(1, 16));
        end
        drive(0, 1, 1, 5);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
